sp_vec: RTL and testbench

- Parametrised multi-lane successor to the single streaming processor.
- Executes one integer instruction across up to 255 threads, LANES threads per beat.
- Fixed-latency result pipeline of depth LAT; lane masking on the final partial batch.
- Sits between warp scheduler/register-file read (operand beats in) and register-file writeback (result beats out).

---
 rtl/sp_pkg.sv | 30 +++
 rtl/sp_lane_alu.sv | 44 ++++
 rtl/sp_vec.sv | 165 ++++++++++++++++
 tb/tb_sp_vec.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_pkg.sv
`default_nettype none
// =====================================================================
// sp_pkg : opcodes, FSM state codes and lane-slice helper for sp_vec
// Revision 1.0
// =====================================================================
package sp_pkg;

    localparam logic [5:0] OP_ADD = 6'h00;
    localparam logic [5:0] OP_SUB = 6'h01;
    localparam logic [5:0] OP_MUL = 6'h02;
    localparam logic [5:0] OP_MAD = 6'h03;
    localparam logic [5:0] OP_MIN = 6'h04;
    localparam logic [5:0] OP_MAX = 6'h05;
    localparam logic [5:0] OP_AND = 6'h06;
    localparam logic [5:0] OP_OR  = 6'h07;
    localparam logic [5:0] OP_XOR = 6'h08;
    localparam logic [5:0] OP_SHL = 6'h09;
    localparam logic [5:0] OP_SHR = 6'h0A;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_ZERO  = 2'd3;

    function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned dw);
        return lane * dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_lane_alu.sv
`default_nettype none
// =====================================================================
// sp_lane_alu : combinational single-lane integer ALU
// Revision 1.0
// =====================================================================
module sp_lane_alu
    import sp_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [DW-1:0] c_i,
    input  logic [5:0]    opcode_i,
    input  logic          sgn_i,
    output logic [DW-1:0] res_o
);

    logic w_lt;

    always_comb begin
        w_lt = sgn_i ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);
    end

    always_comb begin
        res_o = '0;
        case (opcode_i)
            OP_ADD:  res_o = a_i + b_i;
            OP_SUB:  res_o = a_i - b_i;
            OP_MUL:  res_o = a_i * b_i;
            OP_MAD:  res_o = a_i * b_i + c_i;
            OP_MIN:  res_o = w_lt ? a_i : b_i;
            OP_MAX:  res_o = w_lt ? b_i : a_i;
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            OP_SHL:  res_o = a_i << b_i[4:0];
            OP_SHR:  res_o = sgn_i ? DW'($signed(a_i) >>> b_i[4:0]) : (a_i >> b_i[4:0]);
            default: res_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sp_vec.sv
`default_nettype none
// =====================================================================
// sp_vec : multi-lane streaming integer unit, fixed-latency result pipe
// Revision 1.0
// =====================================================================
module sp_vec
    import sp_pkg::*;
#(
    parameter int LANES = 8,
    parameter int DW    = 32,
    parameter int LAT   = 2,
    parameter int BW    = $clog2(256 / LANES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [5:0]          opcode,
    input  logic [2:0]          modifier,
    input  logic                Si,
    input  logic [8:0]          addr_d,
    input  logic [2:0]          Dp,
    input  logic [7:0]          thread_cnt,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [LANES*DW-1:0] rs_a,
    input  logic [LANES*DW-1:0] rs_b,
    input  logic [LANES*DW-1:0] rs_c,
    output logic                out_valid,
    output logic [LANES*DW-1:0] out,
    output logic [LANES-1:0]    out_mask,
    output logic [8:0]          des_addr,
    output logic [2:0]          des_pre,
    output logic [BW-1:0]       sp_cnt,
    output logic                ack,
    output logic                busy
);

    localparam int LOG2L = $clog2(LANES);
    localparam int VW    = LANES * DW;

    logic [1:0]  state_q, state_d;
    logic [5:0]  opc_q;
    logic        sgn_q;
    logic        si_q;
    logic [8:0]  addr_q;
    logic [2:0]  dp_q;
    logic [7:0]  tc_q;
    logic [BW:0] iss_q;

    logic [LAT-1:0]   v_q;
    logic [LAT-1:0]   last_q;
    logic [VW-1:0]    data_q [LAT];
    logic [LANES-1:0] mask_q [LAT];
    logic [BW-1:0]    idx_q  [LAT];

    logic [8:0]       w_nb;
    logic [8:0]       w_rem;
    logic             w_ready;
    logic             w_acc;
    logic             w_last;
    logic             w_ack;
    logic [LANES-1:0] w_mask;
    logic [VW-1:0]    w_res;
    logic             w_unused;

    assign w_unused = &{1'b0, modifier[2:1]};

    assign w_nb    = (9'(tc_q) + 9'(LANES - 1)) >> LOG2L;
    assign w_ready = (state_q == ST_ISSUE) && (9'(iss_q) < w_nb);
    assign w_acc   = op_valid & w_ready;
    assign w_last  = (9'(iss_q) + 9'd1) == w_nb;
    // Threads remaining at this beat; only meaningful on the final batch.
    assign w_rem   = 9'(tc_q) - (9'(iss_q) << LOG2L);
    assign w_ack   = (v_q[LAT-1] & last_q[LAT-1]) | (state_q == ST_ZERO);

    always_comb begin
        w_mask = '0;
        for (int j = 0; j < LANES; j++) begin
            w_mask[j] = !w_last || (9'(j) < w_rem);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DW-1:0] w_b;
        logic [DW-1:0] w_r;
        assign w_b = si_q ? rs_b[DW-1:0] : rs_b[lane_lo(i, DW) +: DW];
        sp_lane_alu #(.DW(DW)) u_alu (
            .a_i      (rs_a[lane_lo(i, DW) +: DW]),
            .b_i      (w_b),
            .c_i      (rs_c[lane_lo(i, DW) +: DW]),
            .opcode_i (opc_q),
            .sgn_i    (sgn_q),
            .res_o    (w_r)
        );
        assign w_res[lane_lo(i, DW) +: DW] = w_mask[i] ? w_r : '0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ena) state_d = (thread_cnt == 8'd0) ? ST_ZERO : ST_ISSUE;
            ST_ISSUE: if (w_acc && w_last) state_d = ST_DRAIN;
            ST_DRAIN: if (w_ack) state_d = ST_IDLE;
            ST_ZERO:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            opc_q   <= '0;
            sgn_q   <= 1'b0;
            si_q    <= 1'b0;
            addr_q  <= '0;
            dp_q    <= '0;
            tc_q    <= '0;
            iss_q   <= '0;
            v_q     <= '0;
            last_q  <= '0;
            for (int s = 0; s < LAT; s++) begin
                data_q[s] <= '0;
                mask_q[s] <= '0;
                idx_q[s]  <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && ena) begin
                opc_q  <= opcode;
                sgn_q  <= modifier[0];
                si_q   <= Si;
                addr_q <= addr_d;
                dp_q   <= Dp;
                tc_q   <= thread_cnt;
                iss_q  <= '0;
            end else if (w_acc) begin
                iss_q <= iss_q + 1'b1;
            end
            v_q[0]    <= w_acc;
            last_q[0] <= w_last;
            data_q[0] <= w_res;
            mask_q[0] <= w_mask;
            idx_q[0]  <= iss_q[BW-1:0];
            for (int s = 1; s < LAT; s++) begin
                v_q[s]    <= v_q[s-1];
                last_q[s] <= last_q[s-1];
                data_q[s] <= data_q[s-1];
                mask_q[s] <= mask_q[s-1];
                idx_q[s]  <= idx_q[s-1];
            end
        end
    end

    assign op_ready  = w_ready;
    assign out_valid = v_q[LAT-1];
    assign out       = v_q[LAT-1] ? data_q[LAT-1] : '0;
    assign out_mask  = v_q[LAT-1] ? mask_q[LAT-1] : '0;
    assign sp_cnt    = v_q[LAT-1] ? idx_q[LAT-1] : '0;
    assign ack       = w_ack;
    assign busy      = (state_q != ST_IDLE);
    assign des_addr  = addr_q;
    assign des_pre   = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_sp_vec.sv
`default_nettype none
// =====================================================================
// tb_sp_vec : randomized self-checking bench for sp_vec (LANES=8, LAT=2)
// Revision 1.0
// =====================================================================
module tb_sp_vec;

    localparam int LANES = 8;
    localparam int DW    = 32;
    localparam int LAT   = 2;
    localparam int BW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic [5:0]       opcode;
    logic [2:0]       modifier;
    logic             Si;
    logic [8:0]       addr_d;
    logic [2:0]       Dp;
    logic [7:0]       thread_cnt;
    logic             op_valid;
    logic             op_ready;
    logic [255:0]     rs_a, rs_b, rs_c;
    logic             out_valid;
    logic [255:0]     out;
    logic [7:0]       out_mask;
    logic [8:0]       des_addr;
    logic [2:0]       des_pre;
    logic [BW-1:0]    sp_cnt;
    logic             ack;
    logic             busy;

    int checks = 0;
    int errors = 0;
    logic [255:0] cap_out;

    always #5 clk = ~clk;

    sp_vec #(.LANES(LANES), .DW(DW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .modifier(modifier),
        .Si(Si), .addr_d(addr_d), .Dp(Dp), .thread_cnt(thread_cnt),
        .op_valid(op_valid), .op_ready(op_ready),
        .rs_a(rs_a), .rs_b(rs_b), .rs_c(rs_c),
        .out_valid(out_valid), .out(out), .out_mask(out_mask),
        .des_addr(des_addr), .des_pre(des_pre), .sp_cnt(sp_cnt),
        .ack(ack), .busy(busy)
    );

    function automatic logic [31:0] ref_alu(input logic [5:0] op, input bit sgn,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
        longint unsigned ua = a, ub = b, uc = c;
        int sa = a, sb = b;
        int sh = int'(b[4:0]);
        case (op)
            6'h00:   return 32'(ua + ub);
            6'h01:   return 32'(ua - ub);
            6'h02:   return 32'(ua * ub);
            6'h03:   return 32'(ua * ub + uc);
            6'h04:   return sgn ? ((sa < sb) ? a : b) : ((ua < ub) ? a : b);
            6'h05:   return sgn ? ((sa > sb) ? a : b) : ((ua > ub) ? a : b);
            6'h06:   return a & b;
            6'h07:   return a | b;
            6'h08:   return a ^ b;
            6'h09:   return 32'(ua << sh);
            6'h0A:   return sgn ? 32'(sa >>> sh) : 32'(ua >> sh);
            default: return 32'h0;
        endcase
    endfunction

    task automatic idle_inputs();
        ena = 0; op_valid = 0;
        opcode = 6'($urandom()); modifier = 3'($urandom()); Si = 1'($urandom());
        addr_d = 9'($urandom()); Dp = 3'($urandom()); thread_cnt = 8'($urandom());
    endtask

    // vmode: 0 = op_valid held high, 1 = toggling 1,0,1,0, 2 = random
    task automatic run_instr(input string nm, input logic [5:0] op, input logic [2:0] md,
                             input logic si, input logic [8:0] ad, input logic [2:0] dp,
                             input int tc, input int vmode, input bit fixed,
                             input logic [31:0] fa, input logic [31:0] fb, input logic [31:0] fc,
                             input bit ena_while_busy);
        int q_due[$];
        logic [255:0] q_dat[$];
        logic [7:0] q_msk[$];
        int q_idx[$];
        bit q_last[$];
        int nb, iss, cyc;
        bit done, exp_rdy, v;
        int e_due, e_idx;
        logic [255:0] e_dat, ea, eb, ec, ed;
        logic [7:0] e_msk, em;
        bit e_last;
        logic [31:0] bj;

        nb = (tc + LANES - 1) / LANES;
        iss = 0; cyc = 0; done = 0;
        ena = 1; opcode = op; modifier = md; Si = si; addr_d = ad; Dp = dp;
        thread_cnt = 8'(tc); op_valid = 0;
        @(posedge clk); #1;
        idle_inputs();

        if (tc == 0) begin
            checks++;
            if (ack !== 1'b1 || out_valid !== 1'b0 || op_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s zero_cnt_ack: ack=%b out_valid=%b op_ready=%b busy=%b, required 1 0 0 1",
                         nm, ack, out_valid, op_ready, busy);
            end
            @(posedge clk); #1;
            checks++;
            if (ack !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || op_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s zero_cnt_after: ack=%b busy=%b out_valid=%b op_ready=%b, required 0 0 0 0",
                         nm, ack, busy, out_valid, op_ready);
            end
            return;
        end

        while (!done && cyc < 200) begin
            exp_rdy = (iss < nb);
            checks++;
            if (op_ready !== exp_rdy || busy !== 1'b1 || des_addr !== ad || des_pre !== dp) begin
                errors++;
                $display("FAIL %s ctrl cyc%0d: op_ready=%b busy=%b des_addr=%h des_pre=%h, required %b 1 %h %h",
                         nm, cyc, op_ready, busy, des_addr, des_pre, exp_rdy, ad, dp);
            end
            if (q_due.size() > 0 && q_due[0] == cyc) begin
                e_due = q_due.pop_front(); e_dat = q_dat.pop_front(); e_msk = q_msk.pop_front();
                e_idx = q_idx.pop_front(); e_last = q_last.pop_front();
                checks++;
                if (out_valid !== 1'b1 || out !== e_dat || out_mask !== e_msk ||
                    sp_cnt !== BW'(e_idx) || ack !== e_last) begin
                    errors++;
                    $display("FAIL %s beat%0d: valid=%b ack=%b sp_cnt=%0d mask=%h out=%h, required 1 %b %0d %h %h",
                             nm, e_idx, out_valid, ack, sp_cnt, out_mask, out, e_last, e_idx, e_msk, e_dat);
                end
                cap_out = out;
                if (e_last) done = 1;
            end else begin
                checks++;
                if (out_valid !== 1'b0 || ack !== 1'b0) begin
                    errors++;
                    $display("FAIL %s idle_out cyc%0d: out_valid=%b ack=%b, required 0 0",
                             nm, cyc, out_valid, ack);
                end
            end

            case (vmode)
                0:       v = 1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom());
            endcase
            if (done) v = 0;
            op_valid = v;
            for (int j = 0; j < LANES; j++) begin
                ea[j*32 +: 32] = fixed ? fa : $urandom();
                eb[j*32 +: 32] = fixed ? fb : $urandom();
                ec[j*32 +: 32] = fixed ? fc : $urandom();
            end
            rs_a = ea; rs_b = eb; rs_c = ec;
            if (ena_while_busy && cyc == 1) begin
                ena = 1; addr_d = ~ad; Dp = ~dp; thread_cnt = 8'd5; opcode = 6'h08;
            end else begin
                ena = 0;
            end
            if (v && exp_rdy) begin
                for (int j = 0; j < LANES; j++) begin
                    bj = si ? eb[31:0] : eb[j*32 +: 32];
                    if (iss * LANES + j < tc) begin
                        ed[j*32 +: 32] = ref_alu(op, md[0], ea[j*32 +: 32], bj, ec[j*32 +: 32]);
                        em[j] = 1'b1;
                    end else begin
                        ed[j*32 +: 32] = 32'h0;
                        em[j] = 1'b0;
                    end
                end
                q_due.push_back(cyc + LAT); q_dat.push_back(ed); q_msk.push_back(em);
                q_idx.push_back(iss); q_last.push_back(iss == nb - 1);
                iss++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        op_valid = 0; ena = 0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s timeout: final ack not seen within 200 cycles, issued=%0d of %0d", nm, iss, nb);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || des_addr !== ad || des_pre !== dp) begin
            errors++;
            $display("FAIL %s after_ack: busy=%b out_valid=%b des_addr=%h des_pre=%h, required 0 0 %h %h",
                     nm, busy, out_valid, des_addr, des_pre, ad, dp);
        end
    endtask

    task automatic check_all_zero(input string nm);
        checks++;
        if (out_valid !== 0 || op_ready !== 0 || busy !== 0 || ack !== 0 || out !== '0 ||
            out_mask !== '0 || des_addr !== '0 || des_pre !== '0 || sp_cnt !== '0) begin
            errors++;
            $display("FAIL %s: valid=%b rdy=%b busy=%b ack=%b mask=%h addr=%h pre=%h cnt=%0d out=%h, required all 0",
                     nm, out_valid, op_ready, busy, ack, out_mask, des_addr, des_pre, sp_cnt, out);
        end
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs(); ena = 1; rs_a = '0; rs_b = '0; rs_c = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        rst = 0; ena = 0;
        @(posedge clk); #1;
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_add_partial();
        run_instr("add_20", 6'h00, 3'd0, 1'b0, 9'h0A5, 3'd3, 20, 0, 0, 0, 0, 0, 0);
        checks++;
        if (cap_out[255:128] !== '0) begin
            errors++;
            $display("FAIL add_20_masked_lanes: upper lanes=%h, required 0", cap_out[255:128]);
        end
    endtask

    task automatic test_mad();
        run_instr("mad", 6'h03, 3'd0, 1'b0, 9'h111, 3'd1, 8, 0, 1, 32'd3, 32'hFFFF_FFFF, 32'd5, 0);
        checks++;
        if (cap_out !== {8{32'h0000_0002}}) begin
            errors++;
            $display("FAIL mad_const: out=%h, required all lanes 00000002", cap_out);
        end
    endtask

    task automatic test_min_shr();
        run_instr("min_u", 6'h04, 3'd0, 1'b0, 9'h001, 3'd0, 8, 0, 1, 32'hFFFF_FFFF, 32'd1, 0, 0);
        checks++;
        if (cap_out[31:0] !== 32'd1) begin
            errors++; $display("FAIL min_unsigned: out=%h, required 00000001", cap_out[31:0]);
        end
        run_instr("min_s", 6'h04, 3'd1, 1'b0, 9'h002, 3'd0, 8, 0, 1, 32'hFFFF_FFFF, 32'd1, 0, 0);
        checks++;
        if (cap_out[31:0] !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL min_signed: out=%h, required ffffffff", cap_out[31:0]);
        end
        run_instr("shr_s", 6'h0A, 3'd1, 1'b0, 9'h003, 3'd0, 8, 0, 1, 32'h8000_0000, 32'd4, 0, 0);
        checks++;
        if (cap_out[31:0] !== 32'hF800_0000) begin
            errors++; $display("FAIL shr_arith: out=%h, required f8000000", cap_out[31:0]);
        end
        run_instr("max_s", 6'h05, 3'd1, 1'b0, 9'h004, 3'd0, 8, 0, 1, 32'hFFFF_FFFF, 32'd1, 0, 0);
        checks++;
        if (cap_out[31:0] !== 32'd1) begin
            errors++; $display("FAIL max_signed: out=%h, required 00000001", cap_out[31:0]);
        end
    endtask

    task automatic test_zero();
        run_instr("zero_cnt", 6'h00, 3'd0, 1'b0, 9'h1F0, 3'd6, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_toggle_second_ena();
        run_instr("toggle16", 6'h07, 3'd0, 1'b0, 9'h0C3, 3'd5, 16, 1, 0, 0, 0, 0, 1);
    endtask

    task automatic test_scalar_b();
        run_instr("si_sub", 6'h01, 3'd0, 1'b1, 9'h077, 3'd2, 13, 2, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        bit stray;
        ena = 1; opcode = 6'h00; modifier = 0; Si = 0; addr_d = 9'h155; Dp = 3'd7;
        thread_cnt = 8'd32; op_valid = 0;
        @(posedge clk); #1;
        ena = 0; op_valid = 1; rs_a = {8{32'h1}}; rs_b = {8{32'h2}};
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        check_all_zero("reset_mid");
        rst = 0;
        stray = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || op_ready !== 1'b0 || busy !== 1'b0) stray = 1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL reset_mid_quiet: activity after reset, required out_valid/op_ready/busy 0");
        end
        op_valid = 0;
        run_instr("after_reset", 6'h02, 3'd0, 1'b0, 9'h0EE, 3'd4, 27, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [5:0] op;
        for (int n = 0; n < 14; n++) begin
            op = (n % 7 == 6) ? 6'h3F : 6'($urandom_range(0, 10));
            run_instr($sformatf("rand%0d", n), op, 3'($urandom()), 1'($urandom()),
                      9'($urandom()), 3'($urandom()), (n == 0) ? 255 : int'($urandom_range(0, 255)),
                      n % 3, 0, 0, 0, 0, (n % 4 == 1));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_partial();
        test_mad();
        test_min_shr();
        test_zero();
        test_toggle_second_ena();
        test_scalar_b();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
